// File: rtl/alu_regfile_datapath.sv
// Register file, ALU, status flags and command sequencer with a valid/ready command port,
// a valid/ready result port and a multi-cycle shift-add multiplier.
module alu_regfile_datapath #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_MOV = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_INC = 4'd5;
    localparam logic [3:0] OP_DEC = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;
    localparam logic [3:0] OP_SHL = 4'd10;
    localparam logic [3:0] OP_SHR = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]   regs [NREGS];
    logic [3:0]         op_q;
    logic [AW-1:0]      rd_q;
    logic [WIDTH-1:0]   imm_q, a_q, b_q;
    logic [3:0]         flags_q;
    logic [2*WIDTH-1:0] mul_acc, mul_mcand, mul_sum;
    logic [CW-1:0]      mul_cnt;
    logic               mul_last;

    logic [WIDTH:0]     ext;
    logic [WIDTH-1:0]   alu_res, opnd_b;
    logic               alu_c, alu_v, alu_wr, alu_err;
    logic [3:0]         exec_flags, mul_flags;

    assign mul_last  = (mul_cnt == CW'(WIDTH - 1));
    assign mul_sum   = mul_acc + (b_q[0] ? mul_mcand : '0);
    assign mul_flags = {mul_sum[WIDTH-1], |mul_sum[2*WIDTH-1:WIDTH],
                        |mul_sum[2*WIDTH-1:WIDTH], mul_sum[WIDTH-1:0] == '0};
    assign exec_flags = {alu_res[WIDTH-1], alu_v, alu_c, alu_res == '0};

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = (cmd_op == OP_MUL) ? S_MUL : S_EXEC;
            end
            S_EXEC: state_nx = S_RESP;
            S_MUL:  if (mul_last) state_nx = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Single-cycle ALU; INC/DEC reuse the add/subtract paths with a constant operand of one
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b1;
        alu_err = 1'b0;
        ext     = '0;
        opnd_b  = (op_q == OP_INC || op_q == OP_DEC) ? WIDTH'(1) : b_q;
        case (op_q)
            OP_LDI: alu_res = imm_q;
            OP_MOV: alu_res = a_q;
            OP_ADD, OP_INC: begin
                ext     = {1'b0, a_q} + {1'b0, opnd_b};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a_q[WIDTH-1] == opnd_b[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                ext     = {1'b0, a_q} - {1'b0, opnd_b};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a_q[WIDTH-1] != opnd_b[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            OP_NOP, OP_MUL: alu_wr = 1'b0;
            default: begin
                alu_wr  = 1'b0;
                alu_err = 1'b1;
            end
        endcase
    end

    // Operands are buffered at accept, so writing rd never disturbs the command in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            flags_q   <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mul_acc   <= '0;
            mul_mcand <= '0;
            mul_cnt   <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        rd_q      <= cmd_rd;
                        imm_q     <= cmd_imm;
                        a_q       <= regs[cmd_ra];
                        b_q       <= regs[cmd_rb];
                        mul_acc   <= '0;
                        mul_mcand <= {WIDTH'(0), regs[cmd_ra]};
                        mul_cnt   <= '0;
                    end
                end
                S_EXEC: begin
                    rsp_err <= alu_err;
                    if (alu_wr) begin
                        regs[rd_q] <= alu_res;
                        flags_q    <= exec_flags;
                        rsp_data   <= alu_res;
                        rsp_flags  <= exec_flags;
                    end else begin
                        rsp_data  <= '0;
                        rsp_flags <= flags_q;
                    end
                end
                S_MUL: begin
                    mul_acc   <= mul_sum;
                    mul_mcand <= mul_mcand << 1;
                    b_q       <= b_q >> 1;
                    mul_cnt   <= mul_cnt + CW'(1);
                    if (mul_last) begin
                        regs[rd_q] <= mul_sum[WIDTH-1:0];
                        flags_q    <= mul_flags;
                        rsp_data   <= mul_sum[WIDTH-1:0];
                        rsp_flags  <= mul_flags;
                        rsp_err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Scoreboard bench for alu_regfile_datapath: directed scenarios plus random commands checked
// against an arithmetic reference model of the register file and flags.
module tb_alu_regfile_datapath;

    localparam int W  = 8;
    localparam int NR = 8;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_op = '0;
    logic [AW-1:0] cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
    logic [W-1:0]  cmd_imm = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  rsp_data;
    logic [3:0]    rsp_flags;
    logic          rsp_err;

    alu_regfile_datapath #(.WIDTH(W), .NREGS(NR)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int   data;
        int   flags;
        int   err;
        int   lat;
        int   acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   m_regs[NR];
    int   m_flags = 0;
    bit   busy = 1'b0;
    bit   seen = 1'b0;
    int   hs_cyc = -1;
    int   last_acc = -1;
    int   rdy_mode = 0;
    int   held = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int sgn(input int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    // Reference model: plain integer arithmetic on the architectural registers and flags
    function automatic exp_t refModel(input int op, input int rd, input int ra, input int rb,
                                      input int imm);
        exp_t e;
        int m = 1 << W;
        int h = m / 2;
        int a = m_regs[ra];
        int b = m_regs[rb];
        int r = 0, c = 0, v = 0, s = 0, bb = 0, p = 0;
        bit wr = 1'b1;
        bit err = 1'b0;
        case (op)
            0: wr = 1'b0;
            1: r = imm;
            2: r = a;
            3, 5: begin
                bb = (op == 5) ? 1 : b;
                s = a + bb;
                r = s % m;
                c = (s >= m);
                s = sgn(a) + sgn(bb);
                v = (s >= h || s < -h);
            end
            4, 6: begin
                bb = (op == 6) ? 1 : b;
                r = (a - bb + m) % m;
                c = (a < bb);
                s = sgn(a) - sgn(bb);
                v = (s >= h || s < -h);
            end
            7:  r = a & b;
            8:  r = a | b;
            9:  r = a ^ b;
            10: begin r = (a * 2) % m; c = (a >= h); end
            11: begin r = a / 2; c = a % 2; end
            12: begin p = a * b; r = p % m; c = (p >= m); v = c; end
            default: begin wr = 1'b0; err = 1'b1; end
        endcase
        if (wr) begin
            m_regs[rd] = r;
            m_flags = ((r >= h) ? 8 : 0) + (v ? 4 : 0) + (c ? 2 : 0) + ((r == 0) ? 1 : 0);
            e.data = r;
        end else begin
            e.data = 0;
        end
        e.flags = m_flags;
        e.err   = err;
        e.lat   = (op == 12) ? W + 1 : 2;
        e.acc   = 0;
        return e;
    endfunction

    task automatic applyStimulus(input int op, input int rd, input int ra, input int rb,
                                 input int imm);
        int   waited = 0;
        exp_t e;
        cmd_op    = op[3:0];
        cmd_rd    = rd[AW-1:0];
        cmd_ra    = ra[AW-1:0];
        cmd_rb    = rb[AW-1:0];
        cmd_imm   = imm[W-1:0];
        cmd_valid = 1'b1;
        forever begin
            @(negedge clock);
            if (cmd_ready && !reset) break;
            waited++;
            if (waited > 200) begin
                checkOutput("accept_timeout", waited, 0);
                cmd_valid = 1'b0;
                return;
            end
        end
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        last_acc  = cyc;
        e = refModel(op, rd, ra, rb, imm);
        e.acc = cyc;
        sb.push_back(e);
        busy = 1'b1;
    endtask

    task automatic waitDrain();
        int k = 0;
        while ((sb.size() != 0 || busy) && k < 500) begin
            @(posedge clock);
            k++;
        end
        #1;
        if (k >= 500) checkOutput("drain_timeout", sb.size(), 0);
    endtask

    task automatic doReset(input int n);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = 0;
        m_flags = 0;
        sb.delete();
        busy = 1'b0;
    endtask

    initial forever begin
        @(posedge clock);
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 3) != 0);
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor: pops one expectation per response, then watches it stay stable until taken
    initial forever begin
        exp_t cur;
        @(negedge clock);
        if (reset) begin
            seen = 1'b0;
        end else begin
            if (busy && !rsp_valid) checkOutput("cmd_ready_busy", cmd_ready, 0);
            if (rsp_valid) begin
                checkOutput("cmd_ready_resp", cmd_ready, 0);
                if (!seen) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_rsp", sb.size(), 1);
                    end else begin
                        cur = sb.pop_front();
                        checkOutput("rsp_data", rsp_data, cur.data);
                        checkOutput("rsp_flags", rsp_flags, cur.flags);
                        checkOutput("rsp_err", rsp_err, cur.err);
                        checkOutput("latency", cyc - cur.acc + 1, cur.lat);
                    end
                    held = {rsp_data, rsp_flags, rsp_err};
                    seen = 1'b1;
                end else begin
                    checkOutput("rsp_stable", {rsp_data, rsp_flags, rsp_err}, held);
                end
                if (rsp_ready) begin
                    hs_cyc = cyc;
                    busy   = 1'b0;
                    seen   = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        doReset(3);
        @(negedge clock);
        checkOutput("reset_cmd_ready", cmd_ready, 1);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_rsp_flags", rsp_flags, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        @(posedge clock);
        #1;

        $display("[TB] load/add/sub/dec/mul");
        applyStimulus(1, 1, 0, 0, 8'h7F);
        applyStimulus(1, 2, 0, 0, 8'h01);
        applyStimulus(3, 3, 1, 2, 0);
        applyStimulus(4, 4, 2, 1, 0);
        applyStimulus(6, 7, 0, 0, 0);
        applyStimulus(12, 5, 1, 1, 0);
        waitDrain();

        $display("[TB] response backpressure");
        rdy_mode = 2;
        applyStimulus(3, 3, 1, 2, 0);
        fork
            applyStimulus(4, 4, 2, 1, 0);
            begin
                k = 0;
                while (!rsp_valid && k < 20) begin
                    @(negedge clock);
                    k++;
                end
                repeat (5) @(posedge clock);
                rdy_mode = 0;
            end
        join
        checkOutput("accept_after_rsp", last_acc, hs_cyc + 2);
        waitDrain();

        $display("[TB] random commands");
        for (int i = 0; i < NR; i++) applyStimulus(1, i, 0, 0, $urandom_range(0, 255));
        rdy_mode = 1;
        repeat (60)
            applyStimulus($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 255));
        waitDrain();
        rdy_mode = 0;

        $display("[TB] illegal opcode and readback");
        applyStimulus(14, 3, 1, 2, 8'h55);
        for (int i = 0; i < NR; i++) applyStimulus(2, i, i, i, 0);
        waitDrain();

        $display("[TB] reset during multiply");
        applyStimulus(1, 1, 0, 0, 8'h7F);
        waitDrain();
        cmd_op = 4'd12; cmd_rd = 3'd6; cmd_ra = 3'd1; cmd_rb = 3'd1; cmd_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!cmd_ready && k < 50);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        doReset(2);
        @(negedge clock);
        checkOutput("abort_cmd_ready", cmd_ready, 1);
        checkOutput("abort_rsp_valid", rsp_valid, 0);
        repeat (12) @(posedge clock);
        #1;
        applyStimulus(2, 6, 6, 6, 0);
        applyStimulus(2, 7, 1, 1, 0);
        waitDrain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
